// File: rtl/systolic_fir_feeder.sv
// Stream controller for the 3-slice systolic FIR array: bubble-spaced issue,
// tagged result capture into an output FIFO, and drain-before-reload of weights.
module systolic_fir_feeder #(
   parameter int WIDTH     = 8,
   parameter int ARRAY_LAT = 3,
   parameter int OUT_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_w3,
   input  logic [WIDTH-1:0] cfg_w2,
   input  logic [WIDTH-1:0] cfg_w1,
   input  logic [WIDTH-1:0] cfg_bias,
   output logic [WIDTH-1:0] x_to_array,
   output logic [WIDTH-1:0] y_bias_to_array,
   output logic [WIDTH-1:0] w3_to_array,
   output logic [WIDTH-1:0] w2_to_array,
   output logic [WIDTH-1:0] w1_to_array,
   input  logic [WIDTH-1:0] results_from_array,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             overflow_err
);

   localparam int AW = $clog2(OUT_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(ARRAY_LAT + 1);
   localparam int SW = $clog2(OUT_DEPTH + ARRAY_LAT + 1);

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      LOAD
   } state_t;

   state_t               state;
   logic                 phase;
   logic [ARRAY_LAT-1:0] tag;
   logic [IW-1:0]        inflight;
   logic [WIDTH-1:0]     mem [OUT_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 issue;
   logic                 push;
   logic                 push_ok;
   logic                 pop;
   logic                 full;
   logic                 empty;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < ARRAY_LAT; i++)
         inflight = inflight + IW'(tag[i]);
   end

   assign empty = (count == '0);
   assign full  = (count == CW'(OUT_DEPTH));

   // Credit counts queued plus in-flight results so a capture never finds the FIFO full.
   assign s_ready = reset_n && (state == RUN) && !phase &&
                    (SW'(count) + SW'(inflight) < SW'(OUT_DEPTH));

   assign issue   = s_valid && s_ready;
   assign push    = tag[ARRAY_LAT-1];
   assign pop     = m_ready && !empty;
   assign push_ok = push && (!full || pop);
   assign m_valid = !empty;
   assign m_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase      <= 1'b0;
         tag        <= '0;
         x_to_array <= '0;
      end else begin
         phase      <= ~phase;
         tag        <= {tag[ARRAY_LAT-2:0], issue};
         x_to_array <= issue ? s_data : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < OUT_DEPTH; i++)
            mem[i] <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= results_from_array;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !push_ok)
            overflow_err <= 1'b1;
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= RUN;
         cfg_ready       <= 1'b0;
         w3_to_array     <= '0;
         w2_to_array     <= '0;
         w1_to_array     <= '0;
         y_bias_to_array <= '0;
      end else begin
         cfg_ready <= 1'b0;
         unique case (1'b1)
            (state == RUN): begin
               if (cfg_valid)
                  state <= DRAIN;
            end
            (state == DRAIN): begin
               if (!cfg_valid) begin
                  state <= RUN;
               end else if (inflight == '0) begin
                  state     <= LOAD;
                  cfg_ready <= 1'b1;
               end
            end
            (state == LOAD): begin
               w3_to_array     <= cfg_w3;
               w2_to_array     <= cfg_w2;
               w1_to_array     <= cfg_w1;
               y_bias_to_array <= cfg_bias;
               state           <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: doc/systolic_fir_feeder.md
Name: systolic_fir_feeder

Overview:
Upstream/downstream controller wrapped around the 3-slice systolic FIR array. It accepts a valid/ready sample stream and injects samples into the array's left x input with mandatory zero bubbles. It tags in-flight samples, captures the array's left-side result after a fixed latency into an output FIFO, and presents results on a valid/ready stream. It also owns the weight/bias registers and reloads them safely by draining the array first.

Parameters:
WIDTH, 8, sample, weight and result width (signed)
ARRAY_LAT, 3, cycles from sample issue edge to the edge where its result is valid on results_from_array
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when high with s_valid
s_data  in  WIDTH  signed input sample
cfg_valid  in  1  weight reload request; held until cfg_ready
cfg_ready  out  1  one-cycle reload acknowledge
cfg_w3, cfg_w2, cfg_w1, cfg_bias  in  WIDTH each  new weights/bias
x_to_array  out  WIDTH  drives array x_in_left
y_bias_to_array  out  WIDTH  drives array y_prev_right
w3_to_array, w2_to_array, w1_to_array  out  WIDTH each  registered weights
results_from_array  in  WIDTH  array results_left
m_valid  out  1  output result valid
m_ready  in  1  downstream accept
m_data  out  WIDTH  signed result
overflow_err  out  1  sticky, FIFO push while full (must never fire)

Behaviour:
- Reset (async, reset_n low): state=RUN, phase=0, weights/bias=0, tag pipe cleared, FIFO empty. All outputs go to 0, including s_ready, cfg_ready, m_valid and overflow_err.
- phase: 1-bit register that toggles every clock. Issue slots exist only when phase==0. x_to_array is registered.
- Issue: s_ready = (state==RUN) && phase==0 && (fifo_count + inflight < OUT_DEPTH).
  - Handshake at edge t loads x_to_array<=s_data and sets tag[0].
  - All other edges load x_to_array<=0, so every sample is followed by at least one zero.
- Tag pipe: ARRAY_LAT-bit shift register, shifted every edge. inflight = popcount.
  - A tag issued at edge t is captured at edge t+ARRAY_LAT. At that edge, results_from_array is pushed into the FIFO.
  - Non-tagged cycles are never captured.
- Credit rule guarantees there is no push while full. If a push does occur at full, the data is dropped and overflow_err is set until reset.
- FIFO:
  - m_valid = !empty; m_data = head entry.
  - m_data is stable while m_valid && !m_ready.
  - Simultaneous push and pop leaves the count unchanged, including at full and at count 1.
  - A pop while empty is a no-op.
  - Pointers wrap modulo OUT_DEPTH.
- Arithmetic: none in this block. Results pass unchanged, two's complement, WIDTH bits.
- FSM:
  - RUN: if cfg_valid, go to DRAIN. An issue handshake in the same cycle still completes.
  - DRAIN: s_ready=0. When inflight==0, go to LOAD. If cfg_valid has dropped, return to RUN without loading.
  - LOAD: cfg_ready=1 for one cycle. At that edge, load w*/bias from cfg_*, then return to RUN. The new weights are visible on the array ports the cycle after LOAD.
- FIFO contents are unaffected by a reload.
- m_ready stall never blocks the reload. DRAIN waits only for inflight, not for the FIFO to empty.
- y_bias_to_array = bias register.

Test Plan:
- Reset mid-stream: 2 samples in flight, 1 FIFO entry, reset_n low for 1 cycle -> all outputs 0, m_valid stays 0 afterwards, and the stale in-flight results are never captured.
- Bubbles: s_valid held 1, data 1,2,3, m_ready=1 -> x_to_array sequence is 1,0,2,0,3,0 and s_ready is high only on phase 0 cycles.
- Latency: bench stub drives results_from_array = x_to_array delayed ARRAY_LAT cycles plus 1. Issue 5 at edge t -> m_valid rises after edge t+3 with m_data=6; the zero bubbles produce no outputs.
- Backpressure: m_ready=0, offer 10 samples -> exactly 4 accepted, then s_ready stays 0 and overflow_err stays 0. Set m_ready=1 -> results drain in order, then the remaining 6 samples are accepted.
- Reload: 2 samples in flight, cfg_valid with w3=3, w2=-2, w1=1, bias=7 -> s_ready is 0 until both results are captured, cfg_ready pulses for 1 cycle, the w ports read 3, -2 (0xFE), 1, 7 the cycle after, and streaming resumes.
- Sign/hold: s_data=-128 (0x80) with the stub from the latency scenario -> m_data=0x81. With m_ready toggled 0/1/0, m_data holds through the stalls and each result is popped once.
